cnoc_indication_serializer: RTL and testbench
=============================================

# cnoc_indication_serializer

Parametrised indication-side CNOC adapter. Arbitrates among `NUM_CHAN` portal indication FIFOs and serialises each selected message onto a single 32-bit CNOC message stream as one header beat followed by `ceil(size/32)` payload beats. Sits between the generated `*IndicationOutput` portal wrapper and the CNOC/host link. It supersedes the fixed two-channel, single-beat combinational header mux with locked multi-beat transfer and fair arbitration.

## Interface
Parameters:
- `NUM_CHAN`, default 2: number of indication channels, 1..16.
- `ID_BASE`, default 0: method id reported for channel 0; channel i reports `ID_BASE+i`.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `ind_notEmpty` in `NUM_CHAN`: channel i has at least one pending message.
- `ind_size` in `16*NUM_CHAN`: channel i message size in bits, slice `[16i+15:16i]`; stable while `ind_notEmpty[i]`.
- `ind_first` in `32*NUM_CHAN`: channel i current payload word.
- `ind_rdy_first` in `NUM_CHAN`: channel i payload word valid.
- `EN_ind_deq` out `NUM_CHAN`: pops one payload word from channel i.
- `indications_0_message_first` out 32: current output beat.
- `RDY_indications_0_message_first` out 1: output beat valid.
- `EN_indications_0_message_deq` in 1: consumer takes the beat; legal only while RDY is high.
- `RDY_indication` out 1: interrupt-level request, `|ind_notEmpty | busy`.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD. Registers: `state`, `chan` (4b), `last_grant` (4b), `remain` (12b), `hdr` (32b).
- IDLE: if any `ind_notEmpty`, grant the first requesting channel searching from `last_grant+1` modulo `NUM_CHAN`. Latch `chan`. Latch `remain = size[15:5] + (size[4:0]!=0)`. Latch `hdr = {ID_BASE+chan [15:0], remain+1 [15:0]}`. Go to HEADER.
- HEADER: output `hdr`, RDY=1. On deq: if `remain==0`, go to IDLE and set `last_grant=chan`; otherwise go to PAYLOAD.
- PAYLOAD: `indications_0_message_first = ind_first[chan]`, `RDY = ind_rdy_first[chan]`, and `EN_ind_deq[chan] = EN_indications_0_message_deq` in the same cycle (combinational). Each deq decrements `remain`. The deq with `remain==1` moves the FSM to IDLE and sets `last_grant=chan`.
- The channel is locked for the whole message. Other channels' `EN_ind_deq` stay 0.
- Arithmetic: header size field = payload words + 1, 16-bit, no overflow (maximum 2048+1). Size 0 gives a header-only message with field value 1.
- A deq while RDY=0 is ignored: no state change and no `EN_ind_deq`.
- Reset values: `state`=IDLE, `last_grant=NUM_CHAN-1` (channel 0 wins first), `remain=0`, `hdr=0`. All outputs 0 except `RDY_indication`, which follows `ind_notEmpty`.
- Reset mid-message: the message is abandoned immediately. Any unpopped words stay in the source FIFO. The source is not repaired.

## Timing
- Request to header valid: 1 cycle (notEmpty sampled in IDLE at edge N, header RDY in cycle N+1).
- Header to first payload: next cycle after the header deq, if `ind_rdy_first` is high.
- Payload: 1 word per cycle at full rate; the output stalls while `ind_rdy_first[chan]` is 0 or the consumer does not deq.
- Inter-message gap: exactly 1 IDLE cycle after the final deq.
- Throughput for a k-word message: k+2 cycles minimum.

## Configuration
- `CNOC_FIXED_PRIORITY_EN` defined: arbitration is fixed priority (lowest requesting index wins) and `last_grant` is not implemented. This is bit-compatible ordering with the legacy two-channel mux.
- `CNOC_FIXED_PRIORITY_EN` undefined (default): round-robin as specified in Operation.

## Test plan
- NUM_CHAN=2, ch0 size=32, word 0xDEADBEEF, consumer always deqs. Required: header 0x0000_0002, then 0xDEADBEEF; `EN_ind_deq[0]` pulses once; `RDY_indication` drops after the FIFO empties.
- ch1 size=0, ID_BASE=5. Required: single beat 0x0006_0001; no `EN_ind_deq`; FSM back in IDLE 1 cycle later.
- ch0 size=100 (4 words), with `ind_rdy_first` low for 3 cycles before word 2. Required: 5 beats; RDY low during the gap; no deq pulses while stalled; remain counts 4→0.
- NUM_CHAN=4, channels 0 and 3 continuously requesting with 1-word messages. Required grant order: 0,3,0,3. With `CNOC_FIXED_PRIORITY_EN` defined: 0,0,0.
- Consumer asserts deq while RDY=0 in PAYLOAD. Required: no `EN_ind_deq`, remain unchanged.
- `RST_N` asserted in PAYLOAD with remain=2. Required: outputs 0 asynchronously; after release, the next grant goes to channel 0 and a fresh header is sent.

Source files
------------

// File: rtl/cnoc_indication_serializer.sv
// Indication-side CNOC adapter: arbitrates NUM_CHAN portal indication FIFOs onto one
// 32-bit message stream (header beat + ceil(size/32) payload beats). Optional macro:
// CNOC_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module cnoc_indication_serializer #(
  parameter int unsigned NUM_CHAN = 2,
  parameter int unsigned ID_BASE  = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_CHAN-1:0]    ind_notEmpty,
  input  logic [16*NUM_CHAN-1:0] ind_size,
  input  logic [32*NUM_CHAN-1:0] ind_first,
  input  logic [NUM_CHAN-1:0]    ind_rdy_first,
  output logic [NUM_CHAN-1:0]    EN_ind_deq,
  output logic [31:0]            indications_0_message_first,
  output logic                   RDY_indications_0_message_first,
  input  logic                   EN_indications_0_message_deq,
  output logic                   RDY_indication
);

  localparam int unsigned CHW  = 4;
  localparam int unsigned REMW = 12;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t            state;
  logic [CHW-1:0]    chan;
  logic [REMW-1:0]   remain;
  logic [31:0]       hdr;
`ifndef CNOC_FIXED_PRIORITY_EN
  logic [CHW-1:0]    last_grant;
`endif

  logic              grant_valid;
  logic [CHW-1:0]    grant_idx;
  int unsigned       arb_best;
  int unsigned       arb_dist;
  logic [15:0]       sel_size;
  logic [31:0]       chan_word;
  logic              chan_rdy;
  logic [REMW-1:0]   rem_calc;
  logic              deq_fire;

  // Arbiter: smallest distance from the preferred start index wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    arb_best    = NUM_CHAN;
    arb_dist    = 0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
`ifdef CNOC_FIXED_PRIORITY_EN
      arb_dist = i;
`else
      arb_dist = (i + 2 * NUM_CHAN - 32'(last_grant) - 1) % NUM_CHAN;
`endif
      if (ind_notEmpty[i] && (arb_dist < arb_best)) begin
        arb_best    = arb_dist;
        grant_valid = 1'b1;
        grant_idx   = CHW'(i);
      end
    end
  end

  // Per-channel selects: size of the candidate, word/valid of the locked channel.
  always_comb begin
    sel_size  = '0;
    chan_word = '0;
    chan_rdy  = 1'b0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      if (grant_idx == CHW'(i)) begin
        sel_size = ind_size[16*i +: 16];
      end
      if (chan == CHW'(i)) begin
        chan_word = ind_first[32*i +: 32];
        chan_rdy  = ind_rdy_first[i];
      end
    end
  end

  assign rem_calc = REMW'(sel_size[15:5]) + REMW'(sel_size[4:0] != 5'd0);

  // Output stream: header from register, payload passed straight from the locked FIFO.
  always_comb begin
    indications_0_message_first     = '0;
    RDY_indications_0_message_first = 1'b0;
    EN_ind_deq                      = '0;
    unique case (state)
      HEADER: begin
        indications_0_message_first     = hdr;
        RDY_indications_0_message_first = 1'b1;
      end
      PAYLOAD: begin
        indications_0_message_first     = chan_word;
        RDY_indications_0_message_first = chan_rdy;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
          if (chan == CHW'(i)) begin
            EN_ind_deq[i] = EN_indications_0_message_deq & chan_rdy;
          end
        end
      end
      default: begin
        indications_0_message_first     = '0;
        RDY_indications_0_message_first = 1'b0;
      end
    endcase
  end

  assign deq_fire       = EN_indications_0_message_deq & RDY_indications_0_message_first;
  assign RDY_indication = (|ind_notEmpty) | (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      chan   <= '0;
      remain <= '0;
      hdr    <= '0;
`ifndef CNOC_FIXED_PRIORITY_EN
      last_grant <= CHW'(NUM_CHAN - 1);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            chan   <= grant_idx;
            remain <= rem_calc;
            hdr    <= {16'(ID_BASE + 32'(grant_idx)), 16'(rem_calc) + 16'd1};
            state  <= HEADER;
          end
        end
        HEADER: begin
          if (deq_fire) begin
            if (remain == '0) begin
              state <= IDLE;
`ifndef CNOC_FIXED_PRIORITY_EN
              last_grant <= chan;
`endif
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (deq_fire) begin
            remain <= remain - REMW'(1);
            if (remain == REMW'(1)) begin
              state <= IDLE;
`ifndef CNOC_FIXED_PRIORITY_EN
              last_grant <= chan;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnoc_indication_serializer.sv
// Bench for cnoc_indication_serializer: FIFO sources with message queues, a message-level
// reference model of the output stream, directed boundary cases and a random phase.
module tb_cnoc_indication_serializer;

  localparam int unsigned NC  = 4;
  localparam int unsigned IDB = 5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [NC-1:0]   ind_notEmpty;
  logic [16*NC-1:0] ind_size;
  logic [32*NC-1:0] ind_first;
  logic [NC-1:0]   ind_rdy_first;
  logic [NC-1:0]   EN_ind_deq;
  logic [31:0]     indications_0_message_first;
  logic            RDY_indications_0_message_first;
  logic            EN_indications_0_message_deq;
  logic            RDY_indication;

  always #5 CLK = ~CLK;

  cnoc_indication_serializer #(.NUM_CHAN(NC), .ID_BASE(IDB)) dut (
    .CLK                             (CLK),
    .RST_N                           (RST_N),
    .ind_notEmpty                    (ind_notEmpty),
    .ind_size                        (ind_size),
    .ind_first                       (ind_first),
    .ind_rdy_first                   (ind_rdy_first),
    .EN_ind_deq                      (EN_ind_deq),
    .indications_0_message_first     (indications_0_message_first),
    .RDY_indications_0_message_first (RDY_indications_0_message_first),
    .EN_indications_0_message_deq    (EN_indications_0_message_deq),
    .RDY_indication                  (RDY_indication)
  );

  // Source FIFOs: one queue of messages per channel, words derived from a seed.
  int unsigned q_size[NC][$];
  logic [31:0] q_seed[NC][$];
  int          src_pos[NC];

  // Reference model of the message stream.
  bit m_busy;
  int m_ch, m_beat, m_nbeats, m_last;

  int hold_low, stall_beat, rdy_prob, deq_prob;
  bit deq;
  logic [31:0] beat_log[$];
  logic [31:0] hdr_log[$];
  int en_cnt[NC];
  int stall_obs;
  int n_cmp, n_err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nwords(int unsigned sz);
    return int'((sz + 31) / 32);
  endfunction

  function automatic logic [31:0] wgen(logic [31:0] seed, int idx);
    return seed + 32'(idx) * 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] at(logic [31:0] q[$], int i);
    if (q.size() > i) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NC; i++) if (q_size[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    int c;
`ifdef CNOC_FIXED_PRIORITY_EN
    for (int i = 0; i < NC; i++) if (q_size[i].size() != 0) return i;
`else
    for (int off = 1; off <= NC; off++) begin
      c = (m_last + off) % NC;
      if (q_size[c].size() != 0) return c;
    end
`endif
    return -1;
  endfunction

  task automatic enq(int ch, int unsigned sz, logic [31:0] seed);
    q_size[ch].push_back(sz);
    q_seed[ch].push_back(seed);
  endtask

  task automatic clear_logs();
    beat_log.delete();
    hdr_log.delete();
    for (int i = 0; i < NC; i++) en_cnt[i] = 0;
    stall_obs = 0;
  endtask

  task automatic drive_sources();
    if (stall_beat >= 0 && m_busy && m_beat == stall_beat) begin
      hold_low   = 3;
      stall_beat = -1;
    end
    for (int i = 0; i < NC; i++) begin
      ind_notEmpty[i]        = (q_size[i].size() != 0);
      ind_size[16*i +: 16]   = '0;
      ind_first[32*i +: 32]  = '0;
      ind_rdy_first[i]       = 1'b0;
      if (q_size[i].size() != 0) begin
        ind_size[16*i +: 16] = 16'(q_size[i][0]);
        if (src_pos[i] < nwords(q_size[i][0])) begin
          ind_first[32*i +: 32] = wgen(q_seed[i][0], src_pos[i]);
          ind_rdy_first[i] = (hold_low == 0) && (int'($urandom_range(99)) < rdy_prob);
        end
      end
    end
    if (hold_low > 0) hold_low--;
  endtask

  // One clock: drive, check against the model, advance the model, cross the edge.
  task automatic cycle();
    logic [31:0] e_word;
    logic        e_rdy;
    logic [NC-1:0] e_en;
    bit fire;
    int c;
    drive_sources();
    deq = (int'($urandom_range(99)) < deq_prob);
    EN_indications_0_message_deq = deq;
    #1;
    e_word = '0;
    e_rdy  = 1'b0;
    e_en   = '0;
    if (m_busy) begin
      if (m_beat == 0) begin
        e_rdy  = 1'b1;
        e_word = {16'(IDB + m_ch), 16'(m_nbeats)};
      end else begin
        e_rdy  = ind_rdy_first[m_ch];
        e_word = wgen(q_seed[m_ch][0], m_beat - 1);
        if (deq && e_rdy) e_en[m_ch] = 1'b1;
      end
    end
    fire = deq && e_rdy;
    chk("rdy", 32'(RDY_indications_0_message_first), 32'(e_rdy));
    chk("en_deq", 32'(EN_ind_deq), 32'(e_en));
    chk("rdy_ind", 32'(RDY_indication), 32'((|ind_notEmpty) || m_busy));
    if (e_rdy || !m_busy) chk("word", indications_0_message_first, e_word);
    for (int i = 0; i < NC; i++) if (EN_ind_deq[i]) en_cnt[i]++;
    if (m_busy && m_beat > 0 && !RDY_indications_0_message_first) stall_obs++;
    if (fire) begin
      beat_log.push_back(indications_0_message_first);
      if (m_beat == 0) hdr_log.push_back(indications_0_message_first);
    end
    if (!m_busy) begin
      c = pick();
      if (c >= 0) begin
        m_busy   = 1'b1;
        m_ch     = c;
        m_beat   = 0;
        m_nbeats = nwords(q_size[c][0]) + 1;
      end
    end else if (fire) begin
      if (m_beat > 0) src_pos[m_ch]++;
      m_beat++;
      if (m_beat == m_nbeats) begin
        m_busy = 1'b0;
        m_last = m_ch;
        void'(q_size[m_ch].pop_front());
        void'(q_seed[m_ch].pop_front());
        src_pos[m_ch] = 0;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drain(string tag, int bound);
    int n;
    n = 0;
    while ((m_busy || pending()) && n < bound) begin
      cycle();
      n++;
    end
    chk(tag, 32'(m_busy || pending()), 32'd0);
  endtask

  // Asynchronous reset mid-cycle; partially popped messages are lost from the source.
  task automatic do_reset();
    drive_sources();
    EN_indications_0_message_deq = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("rst_rdy", 32'(RDY_indications_0_message_first), 32'd0);
    chk("rst_word", indications_0_message_first, 32'd0);
    chk("rst_en", 32'(EN_ind_deq), 32'd0);
    chk("rst_rdy_ind", 32'(RDY_indication), 32'(|ind_notEmpty));
    @(posedge CLK);
    @(negedge CLK);
    RST_N  = 1'b1;
    m_busy = 1'b0;
    m_last = NC - 1;
    for (int i = 0; i < NC; i++) begin
      if (src_pos[i] != 0) begin
        void'(q_size[i].pop_front());
        void'(q_seed[i].pop_front());
        src_pos[i] = 0;
      end
    end
  endtask

  int unsigned bsz[7] = '{0, 1, 31, 32, 33, 64, 65535};
  int unsigned exp_ids[4];

  initial begin
    n_cmp = 0; n_err = 0;
    m_busy = 1'b0; m_last = NC - 1; m_ch = 0; m_beat = 0; m_nbeats = 0;
    hold_low = 0; stall_beat = -1; rdy_prob = 100; deq_prob = 100;
    for (int i = 0; i < NC; i++) src_pos[i] = 0;
    clear_logs();
    ind_notEmpty = '0; ind_size = '0; ind_first = '0; ind_rdy_first = '0;
    EN_indications_0_message_deq = 1'b0;
    RST_N = 1'b0;

    // Reset state, then RDY_indication tracking notEmpty while in reset.
    #1;
    chk("reset_rdy", 32'(RDY_indications_0_message_first), 32'd0);
    chk("reset_word", indications_0_message_first, 32'd0);
    chk("reset_en", 32'(EN_ind_deq), 32'd0);
    chk("reset_rdy_ind_idle", 32'(RDY_indication), 32'd0);
    enq(0, 32, 32'hDEAD_BEEF);
    drive_sources();
    #1;
    chk("reset_rdy_ind_req", 32'(RDY_indication), 32'd1);
    chk("reset_rdy_req", 32'(RDY_indications_0_message_first), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single-word message on channel 0.
    drain("t1_drain", 50);
    chk("t1_nbeats", 32'(beat_log.size()), 32'd2);
    chk("t1_hdr", at(beat_log, 0), 32'h0005_0002);
    chk("t1_word", at(beat_log, 1), 32'hDEAD_BEEF);
    chk("t1_en_cnt", 32'(en_cnt[0]), 32'd1);
    cycle();
    chk("t1_rdy_ind_drop", 32'(RDY_indication), 32'd0);

    // Header-only message on channel 1.
    clear_logs();
    enq(1, 0, 32'h1111_0000);
    drain("t2_drain", 50);
    chk("t2_nbeats", 32'(beat_log.size()), 32'd1);
    chk("t2_hdr", at(beat_log, 0), 32'h0006_0001);
    chk("t2_en_cnt", 32'(en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3]), 32'd0);
    cycle();

    // Four-word message with a 3-cycle source stall; consumer keeps asserting deq.
    clear_logs();
    stall_beat = 2;
    enq(0, 100, 32'h2222_0000);
    drain("t3_drain", 80);
    chk("t3_nbeats", 32'(beat_log.size()), 32'd5);
    chk("t3_hdr", at(beat_log, 0), 32'h0005_0005);
    chk("t3_stall", 32'(stall_obs), 32'd3);
    chk("t3_en_cnt", 32'(en_cnt[0]), 32'd4);

    // Arbitration order with channels 0 and 3 both holding two messages.
    do_reset();
    clear_logs();
    for (int k = 0; k < 2; k++) begin
      enq(0, 32, 32'h3000_0000 + 32'(k));
      enq(3, 32, 32'h3300_0000 + 32'(k));
    end
`ifdef CNOC_FIXED_PRIORITY_EN
    exp_ids = '{IDB, IDB, IDB + 3, IDB + 3};
`else
    exp_ids = '{IDB, IDB + 3, IDB, IDB + 3};
`endif
    drain("t4_drain", 100);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_grant%0d", k), at(hdr_log, k) >> 16, exp_ids[k]);

    // Reset while in PAYLOAD with two words left; channel 0 must win afterwards.
    do_reset();
    clear_logs();
    enq(0, 96, 32'h4000_0000);
    enq(2, 32, 32'h4200_0000);
    begin
      int n;
      n = 0;
      while (!(m_busy && m_beat == 2) && n < 50) begin
        cycle();
        n++;
      end
    end
    chk("t6_reach", 32'(m_busy && m_beat == 2), 32'd1);
    do_reset();
    enq(0, 32, 32'h4400_0000);
    clear_logs();
    drain("t6_drain", 100);
    chk("t6_first_grant", at(hdr_log, 0), 32'h0005_0002);
    chk("t6_second_grant", at(hdr_log, 1), 32'h0007_0002);

    // Size boundaries on channel 2, with moderate backpressure.
    rdy_prob = 80;
    deq_prob = 80;
    foreach (bsz[k]) begin
      clear_logs();
      enq(2, bsz[k], $urandom);
      drain($sformatf("bnd_drain_%0d", bsz[k]), 5000);
      chk($sformatf("bnd_hdr_%0d", bsz[k]), at(hdr_log, 0),
          {16'(IDB + 2), 16'((bsz[k] + 31) / 32 + 1)});
      chk($sformatf("bnd_beats_%0d", bsz[k]), 32'(beat_log.size()), (bsz[k] + 31) / 32 + 1);
    end

    // Random traffic on all channels.
    rdy_prob = 70;
    deq_prob = 70;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) begin
        int ch;
        ch = int'($urandom_range(NC - 1));
        if (q_size[ch].size() < 3) begin
          if ($urandom_range(3) == 0) enq(ch, 32 * $urandom_range(4), $urandom);
          else enq(ch, $urandom_range(300), $urandom);
        end
      end
      cycle();
    end
    drain("rand_drain", 20000);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
